// File: rtl/serial_add_sequencer_if.sv
// Operand/result bus plus the 1-bit adder-cell link for serial_add_sequencer.
// The master drives the request and returns the adder cell's outputs.
// The slave (the sequencer) drives the cell inputs and the results.
interface serial_add_sequencer_if #(
  parameter int unsigned WIDTH = 24
);

  // Request
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  // External 1-bit full-adder cell
  logic             adder_a;
  logic             adder_b;
  logic             adder_cin;
  logic             adder_sum;
  logic             adder_cout;

  // Response
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, op_a, op_b, adder_sum, adder_cout,
    input  adder_a, adder_b, adder_cin,
    input  busy, done, result, carry_out, overflow, zero
  );

  modport slave (
    input  start, sub, op_a, op_b, adder_sum, adder_cout,
    output adder_a, adder_b, adder_cin,
    output busy, done, result, carry_out, overflow, zero
  );

endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract controller driving one external 1-bit full adder,
// LSB first. An operation takes WIDTH cycles in SHIFT, then a one-cycle DONE.
// CNT_W must satisfy 2**CNT_W >= WIDTH.
// Optional macro SERIAL_ADD_FLAGS_EN builds the Overflow/Zero flag logic;
// without it both flags are tied low.
module serial_add_sequencer #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_add_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             sub_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             carry_out_q;
  logic             overflow_q;
  logic             zero_q;

  logic             accept_c;
  logic             in_shift_c;
  logic             last_c;
  logic             adder_a_c;
  logic             adder_b_c;
  logic             adder_cin_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; a new Start is taken in IDLE and in DONE
  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    in_shift_c = 1'b0;
    last_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        in_shift_c = 1'b1;
        if (cnt_q == LAST_BIT) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Adder-cell drive: current bit pair and carry, quiet outside SHIFT
  always_comb begin
    adder_a_c   = 1'b0;
    adder_b_c   = 1'b0;
    adder_cin_c = 1'b0;
    if (in_shift_c) begin
      adder_a_c   = a_q[0];
      adder_b_c   = b_q[0] ^ sub_q;
      adder_cin_c = carry_q;
    end
  end

  // Operand capture, bit shifting, carry chain and completion handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      done_q <= last_c;
      if (accept_c) begin
        a_q     <= bus.op_a;
        b_q     <= bus.op_b;
        sub_q   <= bus.sub;
        carry_q <= bus.sub;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end else if (in_shift_c) begin
        res_q   <= {bus.adder_sum, res_q[WIDTH-1:1]};
        a_q     <= {1'b0, a_q[WIDTH-1:1]};
        b_q     <= {1'b0, b_q[WIDTH-1:1]};
        carry_q <= bus.adder_cout;
        cnt_q   <= cnt_q + CNT_W'(1);
        if (last_c) begin
          carry_out_q <= bus.adder_cout;
          busy_q      <= 1'b0;
        end
      end
    end
  end

`ifdef SERIAL_ADD_FLAGS_EN
  // Status flags: sampled on the final bit; held until the next operation ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (last_c) begin
      overflow_q <= adder_cin_c ^ bus.adder_cout;
      zero_q     <= ({bus.adder_sum, res_q[WIDTH-1:1]} == '0);
    end
  end
`else
  // Flag logic not built
  always_comb begin
    overflow_q = 1'b0;
    zero_q     = 1'b0;
  end
`endif

  assign bus.adder_a   = adder_a_c;
  assign bus.adder_b   = adder_b_c;
  assign bus.adder_cin = adder_cin_c;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = res_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer with a behavioural 1-bit adder
// cell and an arithmetic reference model of add/subtract and the flags.
module tb_serial_add_sequencer;

  localparam int unsigned W  = 24;
  localparam int unsigned W1 = W + 1;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  serial_add_sequencer_if #(.WIDTH(W)) bif ();

  serial_add_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  // External full-adder cell
  assign bif.adder_sum  = bif.adder_a ^ bif.adder_b ^ bif.adder_cin;
  assign bif.adder_cout = (bif.adder_a & bif.adder_b) | (bif.adder_a & bif.adder_cin) |
                          (bif.adder_b & bif.adder_cin);

  always #5 clk = ~clk;

  // Reference: A + B or A + ~B + 1 modulo 2**W, with signed overflow and zero
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] r, output logic co, output logic ov,
                                output logic z);
    logic [W:0] full;
    logic [W-1:0] bb;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + W1'(s);
    r    = full[W-1:0];
    co   = full[W];
`ifdef SERIAL_ADD_FLAGS_EN
    if (s) ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    else   ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    z = (r == '0);
`else
    ov = 1'b0;
    z  = 1'b0;
`endif
  endfunction

  // Drive one Start pulse; returns #1 after the accepting edge E0
  task automatic issue_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bif.start = 1'b1;
    bif.op_a  = a;
    bif.op_b  = b;
    bif.sub   = s;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    bif.op_a  = W'($urandom);
    bif.op_b  = W'($urandom);
    bif.sub   = 1'($urandom);
  endtask

  // Bounded wait for Done; cyc is edges after E0, or -1 on timeout
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= int'(W) + 4; k++) begin
      @(posedge clk);
      #1;
      if (bif.done === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #3;
    n_cmp++;
    if ({bif.busy, bif.done, bif.carry_out, bif.overflow, bif.zero} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 00000",
               {bif.busy, bif.done, bif.carry_out, bif.overflow, bif.zero});
    end
    n_cmp++;
    if (bif.result !== '0) begin
      n_err++;
      $display("FAIL reset_result: got %h expected 000000", bif.result);
    end
    n_cmp++;
    if ({bif.adder_a, bif.adder_b, bif.adder_cin} !== 3'b0) begin
      n_err++;
      $display("FAIL reset_adder: got %b expected 000", {bif.adder_a, bif.adder_b, bif.adder_cin});
    end
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bif.busy, bif.done} !== 2'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b expected 00", {bif.busy, bif.done});
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic         vs [5];
    logic [W-1:0] vr [5];
    logic         vc [5];
    logic [W-1:0] r;
    logic         co, ov, z;
    int           cyc;
    va = '{24'h000005, 24'hFFFFFF, 24'h7FFFFF, 24'h000005, 24'h000007};
    vb = '{24'h000007, 24'h000001, 24'h000001, 24'h000007, 24'h000005};
    vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vr = '{24'h00000C, 24'h000000, 24'h800000, 24'hFFFFFE, 24'h000002};
    vc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      model(va[i], vb[i], vs[i], r, co, ov, z);
      issue_start(va[i], vb[i], vs[i]);
      n_cmp++;
      if ({bif.busy, bif.done} !== 2'b10) begin
        n_err++;
        $display("FAIL dir%0d_busy: got %b expected 10", i, {bif.busy, bif.done});
      end
      wait_done(cyc);
      n_cmp++;
      if (cyc != int'(W)) begin
        n_err++;
        $display("FAIL dir%0d_latency: got %0d expected %0d", i, cyc, W);
      end
      n_cmp++;
      if (bif.result !== vr[i] || bif.carry_out !== vc[i] || bif.busy !== 1'b0) begin
        n_err++;
        $display("FAIL dir%0d_result: got %h c%b busy%b expected %h c%b busy0",
                 i, bif.result, bif.carry_out, bif.busy, vr[i], vc[i]);
      end
      n_cmp++;
      if (bif.overflow !== ov || bif.zero !== z) begin
        n_err++;
        $display("FAIL dir%0d_flags: got v%b z%b expected v%b z%b",
                 i, bif.overflow, bif.zero, ov, z);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bif.done !== 1'b0 || bif.busy !== 1'b0 || bif.result !== vr[i]) begin
        n_err++;
        $display("FAIL dir%0d_hold: got done%b busy%b %h expected done0 busy0 %h",
                 i, bif.done, bif.busy, bif.result, vr[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue_start(24'h000005, 24'h000007, 1'b1);
    wait_done(cyc);
    n_cmp++;
    if (cyc != int'(W) || bif.result !== 24'hFFFFFE || bif.carry_out !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_first: got cyc%0d %h c%b expected cyc%0d fffffe c0",
               cyc, bif.result, bif.carry_out, W);
    end
    issue_start(24'h000007, 24'h000005, 1'b1);
    n_cmp++;
    if ({bif.busy, bif.done} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_restart: got %b expected 10", {bif.busy, bif.done});
    end
    wait_done(cyc);
    n_cmp++;
    if (cyc != int'(W) || bif.result !== 24'h000002 || bif.carry_out !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second: got cyc%0d %h c%b expected cyc%0d 000002 c1",
               cyc, bif.result, bif.carry_out, W);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_start_ignored;
    logic [W-1:0] r, got;
    logic         co, ov, z;
    int           ndone, first;
    model(24'h123456, 24'h0F0F0F, 1'b0, r, co, ov, z);
    issue_start(24'h123456, 24'h0F0F0F, 1'b0);
    ndone = 0;
    first = -1;
    got   = '0;
    for (int k = 1; k <= int'(W) + 6; k++) begin
      @(posedge clk);
      #1;
      if (bif.done === 1'b1) begin
        ndone++;
        if (first < 0) begin
          first = k;
          got   = bif.result;
        end
      end
      if (k == 5) begin
        bif.start = 1'b1;
        bif.op_a  = 24'hABCDEF;
        bif.op_b  = 24'h111111;
        bif.sub   = 1'b1;
      end
      if (k == 6) bif.start = 1'b0;
    end
    n_cmp++;
    if (ndone != 1 || first != int'(W)) begin
      n_err++;
      $display("FAIL ignore_pulses: got %0d pulses at %0d expected 1 at %0d", ndone, first, W);
    end
    n_cmp++;
    if (got !== r) begin
      n_err++;
      $display("FAIL ignore_result: got %h expected %h", got, r);
    end
  endtask

  task automatic test_adder_drive;
    logic [W-1:0] a, b, bb;
    logic [W:0]   mask, t;
    logic         s;
    int           bad;
    a   = W'($urandom);
    b   = W'($urandom);
    s   = 1'($urandom);
    bb  = s ? ~b : b;
    bad = 0;
    issue_start(a, b, s);
    for (int i = 0; i < int'(W); i++) begin
      mask = (W1'(1) << i) - W1'(1);
      t    = ({1'b0, a} & mask) + ({1'b0, bb} & mask) + W1'(s);
      if (bif.adder_a !== a[i] || bif.adder_b !== bb[i] || bif.adder_cin !== t[i]) begin
        bad++;
        if (bad == 1)
          $display("FAIL adder_bit%0d: got a%b b%b c%b expected a%b b%b c%b", i,
                   bif.adder_a, bif.adder_b, bif.adder_cin, a[i], bb[i], t[i]);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL adder_drive: got %0d bad bits expected 0", bad);
    end
    n_cmp++;
    if (bif.done !== 1'b1 || {bif.adder_a, bif.adder_b, bif.adder_cin} !== 3'b0) begin
      n_err++;
      $display("FAIL adder_quiet: got done%b %b expected done1 000",
               bif.done, {bif.adder_a, bif.adder_b, bif.adder_cin});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, r;
    logic         s, co, ov, z;
    int           cyc;
    for (int n = 0; n < 16; n++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (n % 5 == 1) a = {1'b0, {(W-1){1'b1}}};
      if (n % 5 == 2) b = a;
      s = 1'($urandom);
      model(a, b, s, r, co, ov, z);
      issue_start(a, b, s);
      wait_done(cyc);
      n_cmp++;
      if (cyc != int'(W) || bif.result !== r || bif.carry_out !== co ||
          bif.overflow !== ov || bif.zero !== z) begin
        n_err++;
        $display("FAIL rand%0d: a=%h b=%h s=%b got cyc%0d %h c%b v%b z%b expected cyc%0d %h c%b v%b z%b",
                 n, a, b, s, cyc, bif.result, bif.carry_out, bif.overflow, bif.zero,
                 W, r, co, ov, z);
      end
      if (n % 2 == 0) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op;
    int ndone, cyc;
    issue_start(24'h0ABCDE, 24'h012345, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bif.busy, bif.done, bif.carry_out, bif.overflow, bif.zero} !== 5'b0 ||
        bif.result !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: got %b %h expected 00000 000000",
               {bif.busy, bif.done, bif.carry_out, bif.overflow, bif.zero}, bif.result);
    end
    n_cmp++;
    if ({bif.adder_a, bif.adder_b, bif.adder_cin} !== 3'b0) begin
      n_err++;
      $display("FAIL midreset_adder: got %b expected 000", {bif.adder_a, bif.adder_b, bif.adder_cin});
    end
    #1 rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < int'(W) + 4; k++) begin
      @(posedge clk);
      #1;
      if (bif.done === 1'b1 || bif.busy === 1'b1) ndone++;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_err++;
      $display("FAIL midreset_nodone: got %0d active cycles expected 0", ndone);
    end
    issue_start(24'h000003, 24'h000004, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if (cyc != int'(W) || bif.result !== 24'h000007 || bif.carry_out !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_after: got cyc%0d %h c%b expected cyc%0d 000007 c0",
               cyc, bif.result, bif.carry_out, W);
    end
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    n_cmp     = 0;
    n_err     = 0;
    bif.start = 1'b0;
    bif.sub   = 1'b0;
    bif.op_a  = '0;
    bif.op_b  = '0;
    test_reset;
    test_directed;
    test_back_to_back;
    test_start_ignored;
    test_adder_drive;
    test_random;
    test_reset_mid_op;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
